// File: rtl/lift_car_controller.sv
// lift_car_controller
//   Motion controller for a single lift car. Collects floor requests into a
//   pending bitmap and serves them with a SCAN policy. The car keeps moving
//   in its current direction while requests remain ahead of it, then reverses.
//   Travel takes FLOOR_TICKS cycles per floor. The door stays open for
//   DOOR_TICKS cycles at each stop.
//
// Handshake: floor_req_i is level-sampled every cycle and OR-ed into the
//   pending bitmap. There is no ready and no back-pressure. A request stays
//   pending until the car dwells at that floor with the door open.
//
// Ports
//   clk_i        system clock, all state on posedge
//   rst_ni       asynchronous active-low reset
//   floor_req_i  [NFLOOR:0] request bitmap from central_system
//   liftstate_o  [3:0] current floor, binary
//   dir_up_o     1 = committed upward, 0 = downward
//   moving_o     1 while travelling between floors
//   door_open_o  1 while the door dwell is running
//   served_o     [NFLOOR:0] one-cycle one-hot pulse, floor just serviced
//   busy_o       1 while requests are pending or the car is not idle
//   state_o      [1:0] FSM state, exposed for debug/checkers
module lift_car_controller #(
    parameter int NFLOOR      = 10,
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NFLOOR:0]   floor_req_i,
    output logic [3:0]        liftstate_o,
    output logic              dir_up_o,
    output logic              moving_o,
    output logic              door_open_o,
    output logic [NFLOOR:0]   served_o,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    localparam int MAXT = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam logic [CW-1:0] FT_LAST = CW'(FLOOR_TICKS - 1);
    localparam logic [CW-1:0] DT_LAST = CW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NFLOOR:0] pending_q, pending_d;
    logic [3:0]      floor_q, floor_d;
    logic            dir_up_q, dir_up_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NFLOOR:0] served_q, served_d;

    function automatic logic [NFLOOR:0] onehot(input logic [3:0] f);
        logic [NFLOOR:0] oh;
        oh = '0;
        for (int i = 0; i <= NFLOOR; i++) begin
            oh[i] = (i == int'(f));
        end
        return oh;
    endfunction

    function automatic logic any_above(input logic [NFLOOR:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i <= NFLOOR; i++) begin
            if (i > int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NFLOOR:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i <= NFLOOR; i++) begin
            if (i < int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    logic here, above, below;
    logic [3:0] floor_up, floor_dn;

    assign here     = |(pending_q & onehot(floor_q));
    assign above    = any_above(pending_q, floor_q);
    assign below    = any_below(pending_q, floor_q);
    assign floor_up = floor_q + 4'd1;
    assign floor_dn = floor_q - 4'd1;

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        served_d = '0;

        // The current floor's request is cleared for every door cycle, so a
        // repeat request during the dwell is absorbed.
        if (state_q == DOOR) begin
            pending_d = (pending_q | floor_req_i) & ~onehot(floor_q);
        end else begin
            pending_d = pending_q | floor_req_i;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (here) begin
                    state_d = DOOR;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP: begin
                if (cnt_q == FT_LAST) begin
                    // Arrival: decide with the new floor against registered
                    // pending, so a same-edge request is not seen here.
                    cnt_d   = '0;
                    floor_d = floor_up;
                    if (|(pending_q & onehot(floor_up))) begin
                        state_d = DOOR;
                    end else if (any_above(pending_q, floor_up)) begin
                        state_d = MOVE_UP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (cnt_q == FT_LAST) begin
                    cnt_d   = '0;
                    floor_d = floor_dn;
                    if (|(pending_q & onehot(floor_dn))) begin
                        state_d = DOOR;
                    end else if (any_below(pending_q, floor_dn)) begin
                        state_d = MOVE_DOWN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOOR: begin
                if (cnt_q == DT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pulse only on entry to DOOR, giving exactly one served cycle per stop.
        if (state_d == DOOR && state_q != DOOR) begin
            served_d = onehot(floor_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
            served_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
            served_q  <= served_d;
        end
    end

    assign liftstate_o = floor_q;
    assign dir_up_o    = dir_up_q;
    assign moving_o    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign door_open_o = (state_q == DOOR);
    assign served_o    = served_q;
    assign busy_o      = (|pending_q) || (state_q != IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_lift_car_controller.sv
module tb_lift_car_controller;

    localparam int NFLOOR = 10;
    localparam int W      = 20;   // {cycle[15:0], floor[3:0]}

    logic              clk_i;
    logic              rst_ni;
    logic [NFLOOR:0]   floor_req_i;
    logic [3:0]        liftstate_o;
    logic              dir_up_o;
    logic              moving_o;
    logic              door_open_o;
    logic [NFLOOR:0]   served_o;
    logic              busy_o;
    logic [1:0]        state_o;

    lift_car_controller #(.NFLOOR(10), .FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .floor_req_i (floor_req_i),
        .liftstate_o (liftstate_o),
        .dir_up_o    (dir_up_o),
        .moving_o    (moving_o),
        .door_open_o (door_open_o),
        .served_o    (served_o),
        .busy_o      (busy_o),
        .state_o     (state_o)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    int cur_floor = 0;
    int door_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NFLOOR:0] oh(input logic [3:0] f);
        logic [NFLOOR:0] one;
        one = 1;
        return one << f;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk_i) begin
        logic [W-1:0] e;
        if (!rst_ni) begin
            door_run = 0;
        end else begin
            chk("floor_in_range", 32'(liftstate_o <= 4'(NFLOOR)), 32'd1);
            if (door_open_o) begin
                door_run++;
            end else if (door_run != 0) begin
                chk("door_dwell_len", 32'(door_run), 32'd3);
                door_run = 0;
            end
            if (served_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk("served_unexpected", 32'(served_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("served_floor", 32'(served_o), 32'(oh(e[3:0])));
                    chk("served_cycle", 32'(cyc), 32'(e[19:4]));
                    chk("served_door", 32'(door_open_o), 32'd1);
                    chk("served_liftstate", 32'(liftstate_o), 32'(e[3:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int t, input int f);
        exp_q.push_back({16'(t), 4'(f)});
    endtask

    // Drives mask for one cycle; k is the cycle count at the driving negedge.
    task automatic req(input logic [NFLOOR:0] m, output int k);
        @(negedge clk_i);
        floor_req_i = m;
        k = cyc;
        @(negedge clk_i);
        floor_req_i = '0;
    endtask

    task automatic inject_at(input logic [NFLOOR:0] m, input int at);
        while (cyc < at) @(negedge clk_i);
        floor_req_i = m;
        @(negedge clk_i);
        floor_req_i = '0;
    endtask

    task automatic wait_idle(input string name, input int final_floor);
        int i;
        for (i = 0; i < 600; i++) begin
            if (!busy_o) break;
            @(negedge clk_i);
        end
        chk({name, "_idle_timeout"}, 32'(busy_o), 32'd0);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_final_floor"}, 32'(liftstate_o), 32'(final_floor));
        chk({name, "_not_moving"}, 32'(moving_o), 32'd0);
        chk({name, "_door_shut"}, 32'(door_open_o), 32'd0);
        exp_q.delete();
        cur_floor = final_floor;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        cur_floor = 0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_liftstate"}, 32'(liftstate_o), 32'd0);
        chk({name, "_dir_up"},    32'(dir_up_o),    32'd1);
        chk({name, "_moving"},    32'(moving_o),    32'd0);
        chk({name, "_door"},      32'(door_open_o), 32'd0);
        chk({name, "_served"},    32'(served_o),    32'd0);
        chk({name, "_busy"},      32'(busy_o),      32'd0);
        chk({name, "_state"},     32'(state_o),     32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NFLOOR:0] mask;
        int              n;
        logic [15:0]     stops;   // nibble i = i-th expected stop
        logic            dir;     // expected dir_up once idle
    } vec_t;

    vec_t vecs[9];

    initial begin
        int k, t, prev, f, d;
        logic [3:0] fl;

        // Each vector starts idle with nothing pending; car floor follows on.
        vecs[0] = '{11'h001, 1, 16'h0000, 1'b1};  // here at 0
        vecs[1] = '{11'h008, 1, 16'h0003, 1'b1};  // 0 -> 3
        vecs[2] = '{11'h042, 2, 16'h0016, 1'b0};  // at 3 up: 6 then 1
        vecs[3] = '{11'h011, 2, 16'h0040, 1'b1};  // at 1 down: 0 then 4
        vecs[4] = '{11'h400, 1, 16'h000A, 1'b1};  // 4 -> top floor
        vecs[5] = '{11'h601, 3, 16'h009A, 1'b0};  // at 10: 10, 9, 0
        vecs[6] = '{11'h020, 1, 16'h0005, 1'b1};  // at 0 down: reverse to 5
        vecs[7] = '{11'h108, 2, 16'h0038, 1'b0};  // at 5 up: 8 then 3
        vecs[8] = '{11'h202, 2, 16'h0091, 1'b1};  // at 3 down: 1 then 9

        floor_req_i = '0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs("post_reset");

        // ---- table-driven scenarios ----
        for (int v = 0; v < 9; v++) begin
            @(negedge clk_i);
            floor_req_i = vecs[v].mask;
            k = cyc;
            prev = cur_floor;
            t = k + 2;
            for (int s = 0; s < vecs[v].n; s++) begin
                fl = vecs[v].stops[s*4 +: 4];
                f = int'(fl);
                d = (f > prev) ? (f - prev) : (prev - f);
                if (s != 0) t = t + 4;   // door tail cycles plus idle decision
                t = t + 4 * d;
                push_exp(t, f);
                prev = f;
            end
            @(negedge clk_i);
            floor_req_i = '0;
            wait_idle($sformatf("vec%0d", v), prev);
            chk($sformatf("vec%0d_dir", v), 32'(dir_up_o), 32'(vecs[v].dir));
        end

        // ---- en-route request ahead is stopped at (2->3 toward 6, add 4) ----
        do_reset();
        push_exp(0, 0);
        exp_q.delete();
        req(11'h040, k);
        push_exp(k + 18, 4);
        push_exp(k + 30, 6);
        inject_at(11'h010, k + 11);
        wait_idle("enroute", 6);

        // ---- request landing on the arrival edge is passed, served on return ----
        do_reset();
        req(11'h040, k);
        push_exp(k + 26, 6);
        push_exp(k + 42, 3);
        inject_at(11'h008, k + 13);
        wait_idle("same_edge", 3);

        // ---- moving up past 5 with 7 and 2 pending: 7 first, then 2 ----
        do_reset();
        req(11'h080, k);
        push_exp(k + 30, 7);
        push_exp(k + 54, 2);
        inject_at(11'h004, k + 23);
        wait_idle("scan_reverse", 2);

        // ---- repeat request for the current floor during dwell is absorbed ----
        do_reset();
        req(11'h004, k);
        push_exp(k + 10, 2);
        while (cyc < k + 11) @(negedge clk_i);
        chk("absorb_door_open", 32'(door_open_o), 32'd1);
        inject_at(11'h004, k + 11);
        wait_idle("absorb", 2);

        // ---- asynchronous reset mid-travel at floor 4 ----
        do_reset();
        req(11'h100, k);
        push_exp(k + 34, 8);
        for (int i = 0; i < 100; i++) begin
            if (liftstate_o == 4'd4) break;
            @(negedge clk_i);
        end
        chk("midreset_reached4", 32'(liftstate_o), 32'd4);
        chk("midreset_moving", 32'(moving_o), 32'd1);
        #2 rst_ni = 1'b0;
        exp_q.delete();
        #1 chk_reset_outputs("async_reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk_i);
        chk_reset_outputs("after_midreset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit in case a wait misbehaves.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
